// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Package : tdm_pkg
// Purpose : Shared TDM definitions for the TDMO (transmit) and TDMI (receive)
//           blocks: channel geometry, Wishbone channel address decode and the
//           frame bit-pointer type with its advance rule.
// Rev     : 1.0  initial release
// ============================================================================
package tdm_pkg;

  localparam int NUM_CH     = 32;
  localparam int CH_W       = 8;
  localparam int CH_IDX_W   = $clog2(NUM_CH);
  localparam int BIT_IDX_W  = $clog2(CH_W);

  // Channel index lives in the word-address bits of the Wishbone address
  localparam int CH_ADR_LSB = 2;
  localparam int CH_ADR_MSB = CH_ADR_LSB + CH_IDX_W - 1;

  localparam logic WB_ERR_NONE = 1'b0;

  typedef logic [CH_IDX_W-1:0]  ch_idx_t;
  typedef logic [BIT_IDX_W-1:0] bit_idx_t;

  // Position inside a frame: channel, then bit within channel (MSB first)
  typedef struct packed {
    ch_idx_t  ch;
    bit_idx_t bitn;
  } tdm_ptr_t;

  localparam tdm_ptr_t PTR_START = '{ch: '0, bitn: bit_idx_t'(CH_W - 1)};

  // Next position after one bit period; the last bit of the last channel
  // wraps back to the start of the frame.
  function automatic tdm_ptr_t ptr_advance(input tdm_ptr_t p);
    tdm_ptr_t n;
    n = p;
    if (p.bitn == '0) begin
      n.bitn = bit_idx_t'(CH_W - 1);
      n.ch   = (p.ch == ch_idx_t'(NUM_CH - 1)) ? '0 : p.ch + 1'b1;
    end else begin
      n.bitn = p.bitn - 1'b1;
    end
    return n;
  endfunction

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : tdm_sync_edge
// Purpose : N-flop synchronizer for an asynchronous level, plus a history flop
//           that yields a single-clock rising-edge pulse.
// Ports   : clk_i   - sampling clock
//           rst_ni  - asynchronous active-low reset
//           d_i     - raw input level
//           rise_o  - one-clock pulse when the synchronized level goes 0->1
//           hist_o  - synchronized level delayed one more clock
// Rev     : 1.0  initial release
// ============================================================================
module tdm_sync_edge #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic hist_o
);

  logic [N-1:0] sync_q;
  logic         hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      // Shift left; truncation drops the oldest stage and works for N == 1
      sync_q <= N'({sync_q, d_i});
      hist_q <= sync_q[N-1];
    end
  end

  assign rise_o = sync_q[N-1] & ~hist_q;
  assign hist_o = hist_q;

endmodule : tdm_sync_edge
`default_nettype wire

// File: rtl/tdmo.sv
`default_nettype none
// ============================================================================
// Module  : tdmo
// Purpose : TDM serial output port. A Wishbone slave holds NUM_CH channel
//           bytes which are shifted out MSB first on data_out, channel 0
//           first, one bit per ser_clk period, aligned to frame_sync_in.
//           ser_clk and frame_sync_in are sampled as data in the clk domain.
// Ports   : clk, reset (async, active low)
//           ser_clk, frame_sync_in           - TDM bit clock / frame sync in
//           ser_clk_out, frame_sync_out      - copies aligned with data_out
//           data_out                         - serial TDM data
//           i_wb_* / o_wb_*                  - Wishbone slave, adr[6:2]=channel
//           scan_*, test_mode                - DFT hooks, no functional effect
// Rev     : 1.0  initial release
// ============================================================================
module tdmo
  import tdm_pkg::*;
#(
  parameter int SYNC_FF = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ser_clk,
  input  logic        frame_sync_in,
  output logic        frame_sync_out,
  output logic        ser_clk_out,
  output logic        data_out,
  input  logic [31:0] i_wb_adr,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4
);

  logic [CH_W-1:0] chan_q [NUM_CH];
  logic            ack_q;
  logic [31:0]     rdat_q;
  tdm_ptr_t        ptr_q, ptr_d;
  logic            locked_q;
  logic            dout_q;
  logic            sclk_out_q;
  logic            fs_out_q;

  logic            ser_rise, ser_hist;
  logic            fs_rise, fs_hist;
  logic            wb_req;
  ch_idx_t         ch_sel;

  // --------------------------------------------------------------------------
  // Edge detection on the sampled TDM timing inputs
  // --------------------------------------------------------------------------
  tdm_sync_edge #(.N(SYNC_FF)) u_sync_ser (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (ser_clk),
    .rise_o (ser_rise),
    .hist_o (ser_hist)
  );

  tdm_sync_edge #(.N(SYNC_FF)) u_sync_fs (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (frame_sync_in),
    .rise_o (fs_rise),
    .hist_o (fs_hist)
  );

  // --------------------------------------------------------------------------
  // Wishbone slave and channel register file
  // --------------------------------------------------------------------------
  // Gating with !ack forces ack low between back-to-back strobes
  assign wb_req = i_wb_cyc & i_wb_stb & ~ack_q;
  assign ch_sel = i_wb_adr[CH_ADR_MSB:CH_ADR_LSB];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        chan_q[i] <= '0;
      end
    end else begin
      ack_q <= wb_req;
      if (wb_req && i_wb_we) begin
        chan_q[ch_sel] <= i_wb_dat[CH_W-1:0];
      end
      if (wb_req && !i_wb_we) begin
        rdat_q <= {{(32 - CH_W){1'b0}}, chan_q[ch_sel]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame bit pointer. Frame sync always wins and restarts the frame; bit
  // clock edges only advance once a frame sync has been seen after reset.
  // --------------------------------------------------------------------------
  always_comb begin
    ptr_d = ptr_q;
    if (fs_rise) begin
      ptr_d = PTR_START;
    end else if (ser_rise && locked_q) begin
      ptr_d = ptr_advance(ptr_q);
    end
  end

  // The output bit is taken live from the register file every clock, so a
  // write landing before a bit is driven shows up on that bit. The timing
  // outputs take one extra flop past the history stage to line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= PTR_START;
      locked_q   <= 1'b0;
      dout_q     <= 1'b0;
      sclk_out_q <= 1'b0;
      fs_out_q   <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      locked_q   <= locked_q | fs_rise;
      dout_q     <= chan_q[ptr_q.ch][ptr_q.bitn];
      sclk_out_q <= ser_hist;
      fs_out_q   <= fs_hist;
    end
  end

  assign data_out       = dout_q;
  assign ser_clk_out    = sclk_out_q;
  assign frame_sync_out = fs_out_q;
  assign o_wb_ack       = ack_q;
  assign o_wb_dat       = rdat_q;
  assign o_wb_err       = WB_ERR_NONE;

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  // Inputs that are deliberately ignored in the functional build
  logic unused_inputs;
  assign unused_inputs = ^{i_wb_adr[31:CH_ADR_MSB+1], i_wb_adr[CH_ADR_LSB-1:0],
                           i_wb_sel, i_wb_dat[31:CH_W], scan_in0, scan_in1,
                           scan_in2, scan_in3, scan_in4, scan_enable, test_mode};

endmodule : tdmo
`default_nettype wire

// File: tb/tb_tdmo.sv
`default_nettype none
// ============================================================================
// Module  : tb_tdmo
// Purpose : Self-checking bench for tdmo. A frame-position model (bit index
//           0..255 within a frame, plus a byte array of channel contents)
//           predicts every serial bit sampled at the ser_clk falling edge.
// Rev     : 1.0  initial release
// ============================================================================
module tb_tdmo;

  localparam int HALF = 8;   // clk cycles per ser_clk half period
  localparam int NCH  = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        ser_clk;
  logic        frame_sync_in;
  logic        frame_sync_out;
  logic        ser_clk_out;
  logic        data_out;
  logic [31:0] i_wb_adr;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic [31:0] i_wb_dat;
  logic [31:0] o_wb_dat;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        o_wb_ack;
  logic        o_wb_err;
  logic        so0, so1, so2, so3, so4;

  int ntests = 0;
  int nfail  = 0;

  // Reference model state
  logic [7:0] mem [NCH];
  int         pos;        // bit position within the frame, 0 = ch0 bit7
  bit         locked;

  always #5 clk = ~clk;

  tdmo dut (
    .clk            (clk),
    .reset          (reset),
    .ser_clk        (ser_clk),
    .frame_sync_in  (frame_sync_in),
    .frame_sync_out (frame_sync_out),
    .ser_clk_out    (ser_clk_out),
    .data_out       (data_out),
    .i_wb_adr       (i_wb_adr),
    .i_wb_sel       (i_wb_sel),
    .i_wb_we        (i_wb_we),
    .i_wb_dat       (i_wb_dat),
    .o_wb_dat       (o_wb_dat),
    .i_wb_cyc       (i_wb_cyc),
    .i_wb_stb       (i_wb_stb),
    .o_wb_ack       (o_wb_ack),
    .o_wb_err       (o_wb_err),
    .scan_in0       (1'b0),
    .scan_in1       (1'b0),
    .scan_in2       (1'b0),
    .scan_in3       (1'b0),
    .scan_in4       (1'b0),
    .scan_enable    (1'b0),
    .test_mode      (1'b0),
    .scan_out0      (so0),
    .scan_out1      (so1),
    .scan_out2      (so2),
    .scan_out3      (so3),
    .scan_out4      (so4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_bit();
    return mem[pos / 8][7 - (pos % 8)];
  endfunction

  // One Wishbone access; consumes two clocks when ack arrives promptly
  task automatic wb_xfer(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, output logic [31:0] rdat);
    bit got;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_adr = adr;  i_wb_dat = dat;  i_wb_sel = 4'hF;
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (o_wb_ack === 1'b1) got = 1'b1;
    end
    chk("wb_ack_seen", {31'b0, got}, 32'd1);
    rdat = o_wb_dat;
    chk("wb_err", {31'b0, o_wb_err}, 32'd0);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(negedge clk);
    chk("wb_ack_pulse", {31'b0, o_wb_ack}, 32'd0);
  endtask

  task automatic wb_write_ch(input int ch, output logic [7:0] wdat);
    logic [31:0] d, a, rd;
    d = $urandom();
    a = ($urandom() & ~32'h7C) | (ch << 2);   // junk in the ignored address bits
    wb_xfer(1'b1, a, d, rd);
    mem[ch] = d[7:0];
    wdat    = d[7:0];
  endtask

  // One ser_clk period: rise (optionally with frame sync), check at the fall,
  // optionally write a channel during the low phase.
  task automatic bit_cycle(input bit fs, input bit wr, input int wch, output logic samp);
    logic [7:0] wd;
    ser_clk = 1'b1;
    frame_sync_in = fs;
    if (fs) begin
      pos = 0; locked = 1'b1;
    end else if (locked) begin
      pos = (pos + 1) % 256;
    end
    repeat (HALF) @(negedge clk);
    samp = data_out;
    chk("data_out", {31'b0, data_out}, {31'b0, model_bit()});
    chk("fs_out", {31'b0, frame_sync_out}, {31'b0, fs});
    chk("ser_clk_out", {31'b0, ser_clk_out}, 32'd1);
    ser_clk = 1'b0;
    frame_sync_in = 1'b0;
    if (wr) begin
      wb_write_ch(wch, wd);
      repeat (HALF - 2) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s;
    logic [7:0]  acc, expb, oldv, newv, wd;
    logic [31:0] rd;

    reset = 1'b0; ser_clk = 1'b0; frame_sync_in = 1'b0;
    i_wb_adr = '0; i_wb_sel = '0; i_wb_we = 1'b0; i_wb_dat = '0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    for (int i = 0; i < NCH; i++) mem[i] = 8'h00;
    pos = 0; locked = 1'b0;

    // ---- Reset state ----
    repeat (3) @(negedge clk);
    chk("rst_data_out", {31'b0, data_out}, 32'd0);
    chk("rst_ack", {31'b0, o_wb_ack}, 32'd0);
    chk("rst_wb_dat", o_wb_dat, 32'd0);
    chk("rst_fs_out", {31'b0, frame_sync_out}, 32'd0);
    chk("rst_sclk_out", {31'b0, ser_clk_out}, 32'd0);
    chk("rst_err", {31'b0, o_wb_err}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // ---- Test 1: 0xA5 on ch0 ----
    wb_xfer(1'b1, 32'h0, 32'h0000_00A5, rd);
    mem[0] = 8'hA5;
    acc = '0;
    for (int b = 7; b >= 0; b--) begin
      bit_cycle(b == 7, 1'b0, 0, s);
      acc = {acc[6:0], s};
    end
    chk("t1_byte", {24'b0, acc}, 32'h0000_00A5);

    // ---- Test 2: random bytes, write ahead, free-running frames ----
    wb_write_ch(0, wd);
    repeat (HALF) @(negedge clk);
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < NCH; c++) begin
        expb = mem[c];
        acc = '0;
        for (int b = 7; b >= 0; b--) begin
          bit_cycle(f == 0 && c == 0 && b == 7, b == 0, (c + 1) % NCH, s);
          acc = {acc[6:0], s};
        end
        chk("t2_byte", {24'b0, acc}, {24'b0, expb});
      end
    end

    // ---- Test 3: mid-frame resync ----
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(200, 8)) bit_cycle(1'b0, 1'b0, 0, s);
      expb = mem[0];
      acc = '0;
      for (int b = 7; b >= 0; b--) begin
        bit_cycle(b == 7, 1'b0, 0, s);
        acc = {acc[6:0], s};
      end
      chk("t3_resync_byte", {24'b0, acc}, {24'b0, expb});
      repeat (16) bit_cycle(1'b0, 1'b0, 0, s);
    end

    // ---- Test 4: Wishbone write/read, ack shape ----
    wb_xfer(1'b1, 32'h0000_001C, 32'h1234_5678, rd);
    mem[7] = 8'h78;
    wb_xfer(1'b0, 32'h0000_001C, 32'h0, rd);
    chk("t4_read", rd, 32'h0000_0078);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h1C;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("t4_b2b_ack", {31'b0, o_wb_ack}, (n % 2 == 0) ? 32'd1 : 32'd0);
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    repeat (2) @(negedge clk);

    // ---- Test 6: write a channel while it is shifting ----
    bit_cycle(1'b1, 1'b0, 0, s);
    repeat (23) bit_cycle(1'b0, 1'b0, 0, s);
    oldv = mem[3];
    acc = '0;
    for (int b = 7; b >= 0; b--) begin
      bit_cycle(1'b0, b == 5, 3, s);
      acc = {acc[6:0], s};
    end
    newv = mem[3];
    chk("t6_split_byte", {24'b0, acc}, {24'b0, oldv[7:5], newv[4:0]});
    repeat (8) bit_cycle(1'b0, 1'b0, 0, s);

    // ---- Test 5: reset mid-frame ----
    repeat (5) bit_cycle(1'b0, 1'b0, 0, s);
    wb_xfer(1'b1, 32'h0, 32'hFF, rd);   // ch0 all ones so data_out is busy
    mem[0] = 8'hFF;
    bit_cycle(1'b1, 1'b0, 0, s);
    ser_clk = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_pre_rst_data", {31'b0, data_out}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_rst_data", {31'b0, data_out}, 32'd0);
    chk("t5_rst_sclk", {31'b0, ser_clk_out}, 32'd0);
    chk("t5_rst_ack", {31'b0, o_wb_ack}, 32'd0);
    ser_clk = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NCH; i++) mem[i] = 8'h00;
    pos = 0; locked = 1'b0;
    wb_xfer(1'b0, 32'h0, 32'h0, rd);
    chk("t5_rd_ch0", rd, 32'd0);
    wb_xfer(1'b0, 32'h14, 32'h0, rd);
    chk("t5_rd_ch5", rd, 32'd0);
    repeat (6) @(negedge clk);
    wb_write_ch(0, wd);
    wb_write_ch(1, wd);
    repeat (4) bit_cycle(1'b0, 1'b0, 0, s);   // no sync yet: pointer parked
    expb = mem[0];
    acc = '0;
    for (int b = 7; b >= 0; b--) begin
      bit_cycle(b == 7, 1'b0, 0, s);
      acc = {acc[6:0], s};
    end
    chk("t5_restart_byte", {24'b0, acc}, {24'b0, expb});
    repeat (8) bit_cycle(1'b0, 1'b0, 0, s);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule : tb_tdmo
`default_nettype wire
